// File: rtl/commit_pkg.sv
// commit_pkg: shared types for the retirement stage
package commit_pkg;
  localparam int ARF_WIDTH = 5;
  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} commit_state_e;
  typedef struct packed {
    logic [ARF_WIDTH-1:0] areg;
    logic [31:0]          data;
    logic [31:0]          pc;
    logic [31:0]          target;
    logic                 w_reg;
    logic                 w_mem;
    logic                 exc;
    logic                 bpu_fail;
  } rob_commit_entry_t;
endpackage

// File: rtl/commit_perf_cnt.sv
// commit_perf_cnt: wrapping counters of retired instructions and flush pulses
module commit_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  retire_i,
  input  logic        flush_i,
  output logic [31:0] retired_o,
  output logic [31:0] flushes_o
);
  logic [31:0] retired_q, retired_d, flushes_q, flushes_d;
  // accumulate popcount of the retire mask and each flush pulse
  always_comb begin
    retired_d = retired_q + 32'(retire_i[0]) + 32'(retire_i[1]);
    flushes_d = flushes_q + 32'(flush_i);
  end
  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      flushes_q <= '0;
    end else begin
      retired_q <= retired_d;
      flushes_q <= flushes_d;
    end
  end
  assign retired_o = retired_q;
  assign flushes_o = flushes_q;
endmodule

// File: rtl/commit_retire.sv
// commit_retire: in-order dual retire with flush/recover; perf counters under COMMIT_PERF_CNT_EN
module commit_retire
  import commit_pkg::*;
#(
  parameter int          RECOVER_CYCLES = 2,
  parameter logic [31:0] EXC_ENTRY      = 32'h1C00_8000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             rob_valid_i,
  input  logic [1:0]             rob_ready_i,
  input  logic [2*ARF_WIDTH-1:0] rob_areg_i,
  input  logic [63:0]            rob_data_i,
  input  logic [1:0]             rob_w_reg_i,
  input  logic [1:0]             rob_w_mem_i,
  input  logic [1:0]             rob_exc_i,
  input  logic [1:0]             rob_bpu_fail_i,
  input  logic [63:0]            rob_pc_i,
  input  logic [63:0]            rob_target_i,
  output logic [1:0]             retire_o,
  output logic [1:0]             arf_we_o,
  output logic [2*ARF_WIDTH-1:0] arf_waddr_o,
  output logic [63:0]            arf_wdata_o,
  output logic                   sb_commit_valid_o,
  input  logic                   sb_commit_ready_i,
  output logic                   flush_o,
  output logic                   redirect_valid_o,
  output logic [31:0]            redirect_pc_o,
  output logic [31:0]            perf_retired_o,
  output logic [31:0]            perf_flush_o
);
  rob_commit_entry_t     e [2];
  commit_state_e         state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  flush_q, flush_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic [1:0]            arf_we_q, arf_we_d;
  logic [2*ARF_WIDTH-1:0] arf_waddr_q, arf_waddr_d;
  logic [63:0]           arf_wdata_q, arf_wdata_d;
  logic                  run, r0, r1, fault, we0, we1, unused;
  for (genvar g = 0; g < 2; g++) begin : g_way
    assign e[g] = '{areg: rob_areg_i[g*ARF_WIDTH +: ARF_WIDTH], data: rob_data_i[g*32 +: 32],
                    pc: rob_pc_i[g*32 +: 32], target: rob_target_i[g*32 +: 32],
                    w_reg: rob_w_reg_i[g], w_mem: rob_w_mem_i[g], exc: rob_exc_i[g],
                    bpu_fail: rob_bpu_fail_i[g]};
  end
  assign unused = ^{e[0].pc, e[1].pc, e[1].target};
  // retire decision: way1 only behind a clean way0, stores only in way0
  always_comb begin
    run   = state_q == RUN;
    r0    = run & rob_valid_i[0] & rob_ready_i[0] & (!e[0].w_mem | e[0].exc | sb_commit_ready_i);
    r1    = r0 & rob_valid_i[1] & rob_ready_i[1] & !e[1].w_mem &
            !(e[0].exc | e[0].bpu_fail | e[1].exc | e[1].bpu_fail);
    fault = r0 & (e[0].exc | e[0].bpu_fail);
    we1   = r1 & e[1].w_reg & |e[1].areg;
    we0   = r0 & e[0].w_reg & !e[0].exc & |e[0].areg & !(we1 & e[1].areg == e[0].areg);
  end
  assign retire_o          = {r1, r0};
  assign sb_commit_valid_o = run & rob_valid_i[0] & rob_ready_i[0] & e[0].w_mem & !e[0].exc;
  // FSM next state, redirect capture and ARF write staging
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      RUN: if (fault) begin
        state_d       = FLUSH;
        redirect_pc_d = e[0].exc ? EXC_ENTRY : e[0].target;
      end
      FLUSH: begin
        state_d = RECOVER;
        cnt_d   = 4'(RECOVER_CYCLES - 1);
      end
      RECOVER: begin
        state_d = cnt_q == 4'd0 ? RUN : RECOVER;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
    flush_d     = state_d == FLUSH;
    arf_we_d    = {we1, we0};
    arf_waddr_d = {e[1].areg, e[0].areg};
    arf_wdata_d = {e[1].data, e[0].data};
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      arf_we_q      <= '0;
      arf_waddr_q   <= '0;
      arf_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      arf_we_q      <= arf_we_d;
      arf_waddr_q   <= arf_waddr_d;
      arf_wdata_q   <= arf_wdata_d;
    end
  end
  assign flush_o          = flush_q;
  assign redirect_valid_o = flush_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign arf_we_o         = arf_we_q;
  assign arf_waddr_o      = arf_waddr_q;
  assign arf_wdata_o      = arf_wdata_q;
`ifdef COMMIT_PERF_CNT_EN
  commit_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .retire_i  (retire_o),
    .flush_i   (flush_q),
    .retired_o (perf_retired_o),
    .flushes_o (perf_flush_o)
  );
`else
  assign perf_retired_o = '0;
  assign perf_flush_o   = '0;
`endif
endmodule

// File: doc/commit_retire.md
# commit_retire

In-order retirement stage that reads the two oldest ROB entries each cycle and decides how many retire (0, 1 or 2). It returns that count to the ROB as a retire mask, writes results to the ARF, and hands committed stores to the store buffer through a valid/ready handshake. On an exception or branch misprediction it raises a one-cycle pipeline flush with a redirect PC, then holds retirement for a fixed recovery window.

## Interface
Parameters:
- `RECOVER_CYCLES`, default 2: cycles retirement stays blocked after a flush pulse (1..15).
- `EXC_ENTRY`, default 32'h1C00_8000: redirect PC for exceptions.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rob_valid_i`  in  2  ROB entry occupied (way0 = oldest).
- `rob_ready_i`  in  2  entry complete (`c_ready`).
- `rob_areg_i`  in  2×5  destination architectural register.
- `rob_data_i`  in  2×32  result data.
- `rob_w_reg_i`, `rob_w_mem_i`  in  2 each  writes ARF / is store.
- `rob_exc_i`, `rob_bpu_fail_i`  in  2 each  control flags from CDB.
- `rob_pc_i`, `rob_target_i`  in  2×32 each  instruction PC / resolved branch target.
- `retire_o`  out  2  combinational retire mask, thermometer-coded (01 or 11 only); ROB advances tail by popcount.
- `arf_we_o`  out  2  registered ARF write enables.
- `arf_waddr_o`  out  2×5  registered ARF write addresses.
- `arf_wdata_o`  out  2×32  registered ARF write data.
- `sb_commit_valid_o`  out  1  combinational store-commit request.
- `sb_commit_ready_i`  in  1  store buffer accepts.
- `flush_o`  out  1  registered one-cycle flush pulse.
- `redirect_valid_o`  out  1  same cycle as `flush_o`.
- `redirect_pc_o`  out  32  redirect PC.
- `perf_retired_o`, `perf_flush_o`  out  32 each  performance counters.

## Operation
- FSM states: RUN, FLUSH, RECOVER.
- In RUN, way0 is retirable when `valid&ready`. Additional rules for way0:
  - If it is a store, it also needs `sb_commit_ready_i`; `sb_commit_valid_o` = way0 valid&ready&w_mem&!exc.
  - If way0 is not retirable, `retire_o`=00.
- Way1 retires only if way0 retires and all of the following hold:
  - way1 is valid&ready;
  - neither way has exc or bpu_fail;
  - way1 is not a store.
  - Rule: at most one store per cycle, and a store only in way0.
- Faulting way0:
  - exc: retires with no ARF write and no store. FSM goes to FLUSH with redirect = `EXC_ENTRY`.
  - bpu_fail: retires with its normal ARF write. FSM goes to FLUSH with redirect = `rob_target_i[0]`.
- FLUSH, for one cycle: `flush_o`=`redirect_valid_o`=1, `retire_o`=00. Then go to RECOVER with the counter loaded to `RECOVER_CYCLES-1`.
- RECOVER: `retire_o`=00. Decrement the counter; at 0, return to RUN.
- ARF writes:
  - Enable = retire & w_reg & areg≠0.
  - If both ways retire to the same areg, way0's enable is suppressed (way1 is younger).

## Timing
- `retire_o` and `sb_commit_valid_o` are same-cycle combinational from the ROB inputs.
- ARF write outputs are registered: they appear 1 cycle after the retire cycle.
- `flush_o` asserts the cycle after the faulting retire. The first possible RUN retire comes `RECOVER_CYCLES+1` cycles after the flush pulse.
- Reset values: FSM=RUN, counter=0, `arf_we_o`=0, addr/data=0, `flush_o`=`redirect_valid_o`=0, `redirect_pc_o`=0, perf counters=0. Combinational outputs are 0 whenever the inputs are idle.
- Reset asserted mid-FLUSH or mid-RECOVER returns the FSM to RUN immediately (async) and drops `flush_o` at once.
- A store stalled on `sb_commit_ready_i`=0 holds `sb_commit_valid_o` high. Its inputs stay stable because the ROB does not advance.
- Perf counters wrap modulo 2^32.

## Configuration
- `COMMIT_PERF_CNT_EN` defined: `perf_retired_o` adds popcount(`retire_o`) each cycle, and `perf_flush_o` counts flush pulses.
- Not defined: both counters are absent and the outputs are tied to 0.

## Structure
- Shared package `commit_pkg` holds:
  - `commit_state_e` (RUN/FLUSH/RECOVER);
  - `rob_commit_entry_t`: areg, data, pc, target, w_reg, w_mem, exc, bpu_fail;
  - `ARF_WIDTH`=5.
- One sub-module: `commit_perf_cnt`, instantiated only under `COMMIT_PERF_CNT_EN`.

## Test plan
- Two ready ALU ops (areg 3 / areg 4) -> `retire_o`=11 and `retire_o` back to 00; next cycle `arf_we_o`=11 with the matching data.
- Two ready ALU ops both to areg 7 -> `arf_we_o`=10; way1 data written.
- Way0 ready store with `sb_commit_ready_i` low for 3 cycles -> `retire_o`=00 and `sb_commit_valid_o`=1 for 3 cycles; retires (01) on the cycle ready rises.
- Way0 bpu_fail, target 0x1C00_0100, `RECOVER_CYCLES`=2 -> retire 01; next cycle `flush_o`=1 with `redirect_pc_o`=0x1C00_0100; then 2 cycles of `retire_o`=00.
- Way0 exc to areg 5 -> no ARF write; `redirect_pc_o`=`EXC_ENTRY`; `perf_flush_o` increments by 1 (macro defined) / stays 0 (undefined).
- `rst` asserted during RECOVER -> all registered outputs 0 immediately; retire resumes the next cycle after deassert.
